// File: rtl/adder_serial.sv
// Serial adder: {c_out,s} = x + y + c_in, CHUNK bits per clock with a registered inter-chunk carry.
// Latency: out_valid rises exactly WIDTH/CHUNK edges after the accepting edge; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready. Optional macro ADDER_SERIAL_SUB_EN adds a 'sub' port.
module adder_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_serial: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand A shift register
  logic [WIDTH-1:0] b_q, b_d;      // operand B shift register
  logic [WIDTH-1:0] acc_q, acc_d;  // partial sum, filled from the top
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand B and carry as loaded at acceptance (inverted for subtraction).
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;

  // Selects the operand/carry to latch: plain add, or x + ~y + ~c_in when subtracting.
  always_comb begin
    y_eff   = y;
    cin_eff = c_in;
`ifdef ADDER_SERIAL_SUB_EN
    if (sub) begin
      y_eff   = ~y;
      cin_eff = ~c_in;
    end
`endif
  end

  // One chunk of addition and the partial sum with the new chunk shifted in from the top.
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    acc_next  = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Next-state and datapath control; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = x;
          b_d     = y_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        // s/c_out update only on the final chunk so partial sums never appear on s.
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = acc_next;
          c_out_d = chunk_sum[CHUNK];
        end
      end
      DONE: begin
        // No acceptance here even if in_valid and out_ready are both high.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: directed table on an 8/2 instance, random sweeps on 8/8 and 8/1 instances.
// Checks latency, in_ready/out_valid timing, backpressure hold, mid-run reset and the optional subtract mode.
// All expected values come from constants or x+y+c_in computed here.
module tb_adder_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // WIDTH=8, CHUNK=2 instance
  logic       iv2, ir2, ov2, or2, ci2, co2;
  logic [7:0] x2, y2, s2;
`ifdef ADDER_SERIAL_SUB_EN
  logic       sub2;
`endif

  // WIDTH=8, CHUNK=8 instance
  logic       iv8, ir8, ov8, or8, ci8, co8;
  logic [7:0] x8, y8, s8;

  // WIDTH=8, CHUNK=1 instance
  logic       iv1, ir1, ov1, or1, ci1, co1;
  logic [7:0] x1, y1, s1;

  adder_serial #(.WIDTH(8), .CHUNK(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .x(x2), .y(y2), .c_in(ci2),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(sub2),
`endif
    .out_valid(ov2), .out_ready(or2), .s(s2), .c_out(co2));

  adder_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .c_in(ci8),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov8), .out_ready(or8), .s(s8), .c_out(co8));

  adder_serial #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .x(x1), .y(y1), .c_in(ci1),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov1), .out_ready(or1), .s(s1), .c_out(co1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full operation on the 8/2 instance: accept, count latency, hold under backpressure, release.
  // During the release edge in_valid is also high to show DONE never accepts.
  task automatic op2(input string name, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec, input int hold);
    int lat;
    int ir_hi;
    @(negedge clk);
    x2 = a; y2 = b; ci2 = ci; iv2 = 1'b1;
    chk({name, "_ir_idle"}, ir2, 1);
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0; ir_hi = 0;
    while (!ov2 && lat < 40) begin
      if (ir2) ir_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, 4);
    chk({name, "_ir_busy"}, ir_hi, 0);
    chk({name, "_ir_done"}, ir2, 0);
    chk({name, "_sum"}, {co2, s2}, {ec, es});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_vld"}, ov2, 1);
      chk({name, "_hold_sum"}, {co2, s2}, {ec, es});
    end
    or2 = 1'b1; iv2 = 1'b1;
    @(posedge clk); #1;
    or2 = 1'b0; iv2 = 1'b0;
    chk({name, "_rel_vld"}, ov2, 0);
    chk({name, "_rel_ir"}, ir2, 1);
    chk({name, "_rel_keep"}, {co2, s2}, {ec, es});
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst_n = 1'b0;
    iv2 = 0; or2 = 0; ci2 = 0; x2 = 0; y2 = 0;
    iv8 = 0; or8 = 0; ci8 = 0; x8 = 0; y8 = 0;
    iv1 = 0; or1 = 0; ci1 = 0; x1 = 0; y1 = 0;
`ifdef ADDER_SERIAL_SUB_EN
    sub2 = 1'b0;
`endif

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset state, held while rst_n is low.
    #12;
    chk("rst_s", s2, 0);
    chk("rst_co", co2, 0);
    chk("rst_ov", ov2, 0);
    chk("rst_ir", ir2, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op2($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].ci, tbl[i].s, tbl[i].co, 0);
    end

    // Backpressure for 10 cycles; leaves a nonzero result behind for the reset check.
    op2("bp", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 10);

    // Reset two edges into RUN: immediate return to reset values, no result follows.
    @(negedge clk);
    x2 = 8'hAA; y2 = 8'h55; ci2 = 1'b0; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", s2, 0);
    chk("mid_rst_co", co2, 0);
    chk("mid_rst_ov", ov2, 0);
    chk("mid_rst_ir", ir2, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (ov2) seen++;
      end
      chk("mid_rst_no_vld", seen, 0);
      chk("mid_rst_ir_after", ir2, 1);
    end
    op2("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

`ifdef ADDER_SERIAL_SUB_EN
    sub2 = 1'b1;
    op2("sub_a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 0);
    op2("sub_b", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 0);
    sub2 = 1'b0;
    op2("sub_off", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 0);
`endif

    // CHUNK=8: single-edge latency, random operands.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic       c;
      logic [8:0] e;
      int         lat;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom_range(0, 1));
      e = {1'b0, a} + {1'b0, b} + {8'b0, c};
      @(negedge clk);
      x8 = a; y8 = b; ci8 = c; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("c8_lat", lat, 1);
      chk("c8_sum", {co8, s8}, e);
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
    end

    // CHUNK=1: eight-edge latency, random operands.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic       c;
      logic [8:0] e;
      int         lat;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom_range(0, 1));
      e = {1'b0, a} + {1'b0, b} + {8'b0, c};
      @(negedge clk);
      x1 = a; y1 = b; ci1 = c; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("c1_lat", lat, 8);
      chk("c1_sum", {co1, s1}, e);
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
